// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and sizing helpers for the sequential chunk adder
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of chunk additions needed to cover one operand.
    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index register width; kept at least one bit so N=1 still has a real register.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit ripple-carry adder slice
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    // Ripple the carry bit by bit through the slice.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[CHUNK];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle add/subtract, CHUNK bits per clock; ADDER_FLAGS_EN adds zero/ovf outputs
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int N     = num_chunks(WIDTH, CHUNK);
    localparam int IDX_W = idx_bits(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t             state_q, state_d;
    logic               accept;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_s;
    logic               chunk_c;
    logic [WIDTH-1:0]   sum_d;
    logic               last;

    assign last = (idx_q == LAST_IDX);

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the current operand chunk and merge its result into the sum image.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        sum_d   = sum_q;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = op_a_q[i*CHUNK +: CHUNK];
                chunk_b = op_b_q[i*CHUNK +: CHUNK];
                sum_d[i*CHUNK +: CHUNK] = chunk_s;
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .s    (chunk_s),
        .cout (chunk_c)
    );

    // Operand latch on accept, then one chunk per RUN cycle with the carry chained through carry_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADDER_FLAGS_EN
            zero    <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            idx_q   <= '0;
            op_a_q  <= a;
            op_b_q  <= b ^ {WIDTH{sub}};
            carry_q <= sub ? 1'b1 : cin;
        end else if (state_q == RUN) begin
            sum_q   <= sum_d;
            carry_q <= chunk_c;
            idx_q   <= idx_q + IDX_W'(1);
            if (last) begin
                cout_q <= chunk_c;
`ifdef ADDER_FLAGS_EN
                zero   <= (sum_d == '0);
                ovf    <= (chunk_a[CHUNK-1] == chunk_b[CHUNK-1]) &&
                          (chunk_s[CHUNK-1] != chunk_a[CHUNK-1]);
`endif
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - self-checking bench for seq_chunk_adder in CHUNK=4, 32 and 1 builds
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        sub, cin;
    logic        start_c4, start_c32, start_c1;

    logic        busy_c4, done_c4, cout_c4;
    logic        busy_c32, done_c32, cout_c32;
    logic        busy_c1, done_c1, cout_c1;
    logic [31:0] sum_c4, sum_c32, sum_c1;
`ifdef ADDER_FLAGS_EN
    logic        zero_c4, ovf_c4, zero_c32, ovf_c32, zero_c1, ovf_c1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start_c4), .a(a), .b(b), .sub(sub), .cin(cin),
        .busy(busy_c4), .done(done_c4), .sum(sum_c4), .cout(cout_c4)
`ifdef ADDER_FLAGS_EN
        , .zero(zero_c4), .ovf(ovf_c4)
`endif
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .rst(rst), .start(start_c32), .a(a), .b(b), .sub(sub), .cin(cin),
        .busy(busy_c32), .done(done_c32), .sum(sum_c32), .cout(cout_c32)
`ifdef ADDER_FLAGS_EN
        , .zero(zero_c32), .ovf(ovf_c32)
`endif
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start_c1), .a(a), .b(b), .sub(sub), .cin(cin),
        .busy(busy_c1), .done(done_c1), .sum(sum_c1), .cout(cout_c1)
`ifdef ADDER_FLAGS_EN
        , .zero(zero_c1), .ovf(ovf_c1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 33-bit arithmetic; for subtract, carry-out means "no borrow".
    function automatic logic [32:0] ref_res(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input logic ci);
        logic [32:0] r;
        if (s) begin
            r[31:0] = x - y;
            r[32]   = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y,
                                     input logic s, input logic [31:0] res);
        logic [31:0] yi;
        yi = s ? ~y : y;
        return (x[31] == yi[31]) && (res[31] != x[31]);
    endfunction

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tsub, input logic tcin,
                          input bit en4, input bit en32, input bit en1);
        logic [32:0] exp;
        int          lat [3];
        int          nd  [3];
        logic [31:0] s   [3];
        logic        c   [3];
        logic        z   [3];
        logic        o   [3];
        int          nexp [3];
        bit          en  [3];
        exp  = ref_res(ta, tb, tsub, tcin);
        nexp = '{8, 1, 32};
        en   = '{en4, en32, en1};
        for (int j = 0; j < 3; j++) begin
            lat[j] = 0; nd[j] = 0; s[j] = '0; c[j] = 1'b0; z[j] = 1'b0; o[j] = 1'b0;
        end
        a = ta; b = tb; sub = tsub; cin = tcin;
        start_c4 = en4; start_c32 = en32; start_c1 = en1;
        @(posedge clk); #1;
        start_c4 = 1'b0; start_c32 = 1'b0; start_c1 = 1'b0;
        // Scramble inputs after acceptance; the latched operands must be used.
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
        if (en4) chk({tag, " busy_c4"}, 64'(busy_c4), 64'd1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done_c4) begin
                nd[0]++;
                if (lat[0] == 0) begin
                    lat[0] = k; s[0] = sum_c4; c[0] = cout_c4;
`ifdef ADDER_FLAGS_EN
                    z[0] = zero_c4; o[0] = ovf_c4;
`endif
                end
            end
            if (done_c32) begin
                nd[1]++;
                if (lat[1] == 0) begin
                    lat[1] = k; s[1] = sum_c32; c[1] = cout_c32;
`ifdef ADDER_FLAGS_EN
                    z[1] = zero_c32; o[1] = ovf_c32;
`endif
                end
            end
            if (done_c1) begin
                nd[2]++;
                if (lat[2] == 0) begin
                    lat[2] = k; s[2] = sum_c1; c[2] = cout_c1;
`ifdef ADDER_FLAGS_EN
                    z[2] = zero_c1; o[2] = ovf_c1;
`endif
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (en[j]) begin
                chk($sformatf("%s dut%0d latency", tag, j), 64'(lat[j]), 64'(nexp[j]));
                chk($sformatf("%s dut%0d done_count", tag, j), 64'(nd[j]), 64'd1);
                chk($sformatf("%s dut%0d sum", tag, j), 64'(s[j]), 64'(exp[31:0]));
                chk($sformatf("%s dut%0d cout", tag, j), 64'(c[j]), 64'(exp[32]));
`ifdef ADDER_FLAGS_EN
                chk($sformatf("%s dut%0d zero", tag, j), 64'(z[j]), 64'(exp[31:0] == 32'd0));
                chk($sformatf("%s dut%0d ovf", tag, j), 64'(o[j]),
                    64'(ref_ovf(ta, tb, tsub, exp[31:0])));
`endif
            end
        end
        if (en4) chk({tag, " held_c4"}, 64'(sum_c4), 64'(exp[31:0]));
    endtask

    initial begin
        logic [32:0] exp1;
        int          nd;
        int          ld;
        logic [31:0] s1;
        logic        c1;

        rst = 1'b1; start_c4 = 1'b0; start_c32 = 1'b0; start_c1 = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'({busy_c4, busy_c32, busy_c1}), 64'd0);
        chk("reset done", 64'({done_c4, done_c32, done_c1}), 64'd0);
        chk("reset sum", 64'(sum_c4 | sum_c32 | sum_c1), 64'd0);
        chk("reset cout", 64'({cout_c4, cout_c32, cout_c1}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("t1 5+3",        32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1, 1, 1);
        run_op("t2 carry",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1, 1);
        run_op("t3 3-5",        32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 1, 1, 1);
        run_op("t3 3-5 cin",    32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 1, 1, 1);
        run_op("t4 ovf",        32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1, 1);
        run_op("t cin add",     32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 1, 1, 1);
        run_op("t equal sub",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1, 1, 1);

        // Start pulses mid-op and in the DONE cycle must be ignored.
        exp1 = ref_res(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
        a = 32'h0000_1111; b = 32'h0000_2222; sub = 1'b0; cin = 1'b0; start_c4 = 1'b1;
        @(posedge clk); #1;
        start_c4 = 1'b0;
        nd = 0; ld = 0; s1 = '0; c1 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            start_c4 = (k == 2 || k == 8 || k == 9);
            @(posedge clk); #1;
            if (done_c4) begin
                nd++;
                if (nd == 1) begin
                    ld = k; s1 = sum_c4; c1 = cout_c4;
                end
            end
        end
        start_c4 = 1'b0;
        chk("t5 done_count", 64'(nd), 64'd1);
        chk("t5 latency", 64'(ld), 64'd8);
        chk("t5 sum", 64'(s1), 64'(exp1[31:0]));
        chk("t5 cout", 64'(c1), 64'(exp1[32]));
        chk("t5 sum_held", 64'(sum_c4), 64'(exp1[31:0]));
        chk("t5 idle", 64'(busy_c4), 64'd0);
        run_op("t5 after",      32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 1'b0, 1, 0, 0);

        // Reset in the middle of RUN aborts with no done pulse.
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; sub = 1'b0; cin = 1'b1; start_c4 = 1'b1;
        @(posedge clk); #1;
        start_c4 = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("t6 busy", 64'(busy_c4), 64'd0);
        chk("t6 done", 64'(done_c4), 64'd0);
        chk("t6 sum", 64'(sum_c4), 64'd0);
        chk("t6 cout", 64'(cout_c4), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done_c4) nd++;
        end
        chk("t6 no_done", 64'(nd), 64'd0);
        run_op("t6 after",      32'h0F0F_0F0F, 32'h00FF_00FF, 1'b1, 1'b0, 1, 0, 0);

        // Random operands on all three chunk sizes.
        for (int r = 0; r < 24; r++) begin
            run_op($sformatf("rnd%0d", r), $urandom, $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
